// File: rtl/display_scan_arbiter_pkg.sv
// Shared constants, owner state encoding and the state-to-grant mapping
// for the seven-segment display arbiter.
package display_scan_arbiter_pkg;

  // All digit enables off (enables are active-low)
  localparam logic [3:0] AN_OFF     = 4'b1111;
  // No source owns the display
  localparam logic [1:0] GRANT_NONE = 2'b00;

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_0    = 2'd1,
    OWN_1    = 2'd2
  } own_state_t;

  // One-hot grant vector for an owner state
  function automatic logic [1:0] grant_of(input own_state_t s);
    case (s)
      OWN_0:   return 2'b01;
      OWN_1:   return 2'b10;
      default: return GRANT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/display_scan_timer.sv
// Digit scan timer: slot counter and digit index. Besides the frame
// boundary flag for the current cycle, it publishes the digit, blank phase
// and slot-start flag that the counters are about to take on, so that the
// parent can register its display outputs in step with the scan.
module display_scan_timer #(
  parameter int SCAN_DIV  = 262144,
  parameter int BLANK_CYC = 1024
) (
  input  logic       CLK,
  input  logic       Reset,
  output logic [1:0] digit_next,
  output logic       blank_next,
  output logic       slot_start_next,
  output logic       fb
);

  localparam int            CW        = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);

  logic [CW-1:0] slot_cnt_reg;
  logic [CW-1:0] slot_cnt_next;
  logic [1:0]    digit_reg;
  logic          slot_wrap;

  // Advance the slot counter; step the digit when the slot wraps
  always_comb begin
    slot_wrap     = (slot_cnt_reg == SLOT_LAST);
    slot_cnt_next = slot_wrap ? '0 : slot_cnt_reg + CW'(1);
    digit_next    = slot_wrap ? digit_reg + 2'd1 : digit_reg;
  end

  assign blank_next      = (slot_cnt_next < BLANK_LIM);
  assign slot_start_next = (slot_cnt_next == '0);
  assign fb              = slot_wrap && (digit_reg == 2'd3);

  // Scan counters; reset restarts at digit 0, slot cycle 0
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      slot_cnt_reg <= '0;
      digit_reg    <= 2'd0;
    end else begin
      slot_cnt_reg <= slot_cnt_next;
      digit_reg    <= digit_next;
    end
  end

endmodule

// File: rtl/display_scan_arbiter.sv
// Time-shares the 4-digit display between two 16-bit sources. Ownership
// changes only at frame boundaries, with a minimum dwell while contended,
// and each frame shows a snapshot of the owner taken at the boundary.
module display_scan_arbiter
  import display_scan_arbiter_pkg::*;
#(
  parameter int SCAN_DIV   = 262144,
  parameter int BLANK_CYC  = 1024,
  parameter int MIN_FRAMES = 8
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [1:0]  Req,
  input  logic [15:0] Data0,
  input  logic [15:0] Data1,
  output logic [1:0]  Grant,
  output logic [3:0]  AN,
  output logic [3:0]  Code,
  output logic        Frame_Done
);

  localparam int            FW      = $clog2(MIN_FRAMES + 1);
  localparam logic [FW-1:0] MIN_LIM = FW'(MIN_FRAMES);

  logic [1:0] digit_next;
  logic       blank_next;
  logic       slot_start_next;
  logic       fb;

  own_state_t    state_reg, state_next;
  logic [FW-1:0] frames_reg, frames_next, frames_done;
  logic          last_reg, last_next;
  logic [15:0]   shadow_reg, shadow_next;
  logic [1:0]    grant_reg, grant_next;
  logic [3:0]    an_reg, an_next;
  logic [3:0]    code_reg, code_next;
  logic          frame_done_reg;
  logic          dwell_met;
  logic [3:0]    an_sel;

  display_scan_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .CLK             (CLK),
    .Reset           (Reset),
    .digit_next      (digit_next),
    .blank_next      (blank_next),
    .slot_start_next (slot_start_next),
    .fb              (fb)
  );

  // The frame ending now counts toward dwell, so an owner contended from
  // its first frame yields after exactly MIN_FRAMES frames on screen.
  assign frames_done = (frames_reg >= MIN_LIM) ? MIN_LIM : frames_reg + FW'(1);
  assign dwell_met   = (frames_done >= MIN_LIM);

  // Owner FSM, evaluated only on frame-boundary cycles
  always_comb begin
    state_next = state_reg;
    if (fb) begin
      case (state_reg)
        OWN_IDLE: begin
          if (Req == 2'b11)  state_next = last_reg ? OWN_0 : OWN_1;
          else if (Req[0])   state_next = OWN_0;
          else if (Req[1])   state_next = OWN_1;
        end
        OWN_0: begin
          if (!Req[0])                  state_next = Req[1] ? OWN_1 : OWN_IDLE;
          else if (Req[1] && dwell_met) state_next = OWN_1;
        end
        OWN_1: begin
          if (!Req[1])                  state_next = Req[0] ? OWN_0 : OWN_IDLE;
          else if (Req[0] && dwell_met) state_next = OWN_0;
        end
        default: state_next = OWN_IDLE;
      endcase
    end
  end

  // Dwell count, tie-break history and frame snapshot, all taken at the boundary
  always_comb begin
    frames_next = frames_reg;
    last_next   = last_reg;
    shadow_next = shadow_reg;
    if (fb) begin
      frames_next = (state_next != state_reg) ? '0 : frames_done;
      case (state_next)
        OWN_0: begin
          last_next   = 1'b0;
          shadow_next = Data0;
        end
        OWN_1: begin
          last_next   = 1'b1;
          shadow_next = Data1;
        end
        default: shadow_next = 16'h0000;
      endcase
    end
  end

  // One-hot digit decode for the upcoming cycle
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_an_sel
      assign an_sel[gi] = (digit_next == 2'(gi));
    end
  endgenerate

  // Output values for the next cycle; Code only moves at slot start
  always_comb begin
    grant_next = grant_of(state_next);
    an_next    = (blank_next || (grant_next == GRANT_NONE)) ? AN_OFF : ~an_sel;
    code_next  = slot_start_next ? shadow_next[{digit_next, 2'b00} +: 4] : code_reg;
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_reg      <= OWN_IDLE;
      frames_reg     <= '0;
      last_reg       <= 1'b1;
      shadow_reg     <= 16'h0000;
      grant_reg      <= GRANT_NONE;
      an_reg         <= AN_OFF;
      code_reg       <= 4'h0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      frames_reg     <= frames_next;
      last_reg       <= last_next;
      shadow_reg     <= shadow_next;
      grant_reg      <= grant_next;
      an_reg         <= an_next;
      code_reg       <= code_next;
      frame_done_reg <= fb;
    end
  end

  assign Grant      = grant_reg;
  assign AN         = an_reg;
  assign Code       = code_reg;
  assign Frame_Done = frame_done_reg;

endmodule

// File: tb/tb_display_scan_arbiter.sv
// Scoreboard bench for display_scan_arbiter with SCAN_DIV=8, BLANK_CYC=2,
// MIN_FRAMES=2 (32-cycle frames). Expected per-cycle outputs are pushed
// frame by frame when the stimulus is set up, then popped and compared
// one cycle at a time, sampling 1 time unit after each rising edge.
module tb_display_scan_arbiter;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FL = 4 * SD;

  logic        CLK;
  logic        Reset;
  logic [1:0]  Req;
  logic [15:0] Data0;
  logic [15:0] Data1;
  logic [1:0]  Grant;
  logic [3:0]  AN;
  logic [3:0]  Code;
  logic        Frame_Done;

  typedef struct {
    int         tag;
    int         cyc;
    logic [1:0] grant;
    logic [3:0] an;
    logic [3:0] code;
    logic       fd;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  display_scan_arbiter #(
    .SCAN_DIV   (SD),
    .BLANK_CYC  (BC),
    .MIN_FRAMES (2)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .Req        (Req),
    .Data0      (Data0),
    .Data1      (Data1),
    .Grant      (Grant),
    .AN         (AN),
    .Code       (Code),
    .Frame_Done (Frame_Done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected outputs for one whole frame shown with grant g and snapshot d
  task automatic push_frame(input logic [1:0] g, input logic [15:0] d,
                            input logic fd0, input int tag);
    exp_t e;
    for (int c = 0; c < FL; c++) begin
      int dg = c / SD;
      int sc = c % SD;
      e.tag   = tag;
      e.cyc   = c;
      e.grant = g;
      e.an    = (sc < BC || g == 2'b00) ? 4'b1111 : 4'(~(4'b0001 << dg));
      e.code  = d[dg*4 +: 4];
      e.fd    = (c == 0) ? fd0 : 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    exp_t e;
    Reset = 1'b0;
    Req   = 2'b11;
    Data0 = 16'h1234;
    Data1 = 16'hABCD;
    for (int k = 0; k < 2; k++) begin
      e.tag = 0; e.cyc = -2 + k; e.grant = 2'b00; e.an = 4'b1111; e.code = 4'h0; e.fd = 1'b0;
      sb.push_back(e);
    end
    push_frame(2'b00, 16'h0000, 1'b0, 0);
    tick();
    for (int k = 0; k < 2 + FL; k++) begin
      e = sb.pop_front();
      n_tests += 4;
      if (Grant !== e.grant) begin n_fail++; $display("FAIL reset grant f%0d c%0d: got %b want %b", e.tag, e.cyc, Grant, e.grant); end
      if (AN !== e.an) begin n_fail++; $display("FAIL reset an f%0d c%0d: got %b want %b", e.tag, e.cyc, AN, e.an); end
      if (Code !== e.code) begin n_fail++; $display("FAIL reset code f%0d c%0d: got %h want %h", e.tag, e.cyc, Code, e.code); end
      if (Frame_Done !== e.fd) begin n_fail++; $display("FAIL reset frame_done f%0d c%0d: got %b want %b", e.tag, e.cyc, Frame_Done, e.fd); end
      if (k == 2) Reset = 1'b1;
      if (e.cyc == FL - 1) $display("[TB] reset: frame %0d checked", e.tag);
      tick();
    end
  endtask

  task automatic test_tie_dwell();
    exp_t e;
    push_frame(2'b01, 16'h1234, 1'b1, 1);
    push_frame(2'b01, 16'h1234, 1'b1, 2);
    push_frame(2'b10, 16'hABCD, 1'b1, 3);
    push_frame(2'b10, 16'hABCD, 1'b1, 4);
    push_frame(2'b01, 16'h1234, 1'b1, 5);
    for (int k = 0; k < 5 * FL; k++) begin
      e = sb.pop_front();
      n_tests += 4;
      if (Grant !== e.grant) begin n_fail++; $display("FAIL tie grant f%0d c%0d: got %b want %b", e.tag, e.cyc, Grant, e.grant); end
      if (AN !== e.an) begin n_fail++; $display("FAIL tie an f%0d c%0d: got %b want %b", e.tag, e.cyc, AN, e.an); end
      if (Code !== e.code) begin n_fail++; $display("FAIL tie code f%0d c%0d: got %h want %h", e.tag, e.cyc, Code, e.code); end
      if (Frame_Done !== e.fd) begin n_fail++; $display("FAIL tie frame_done f%0d c%0d: got %b want %b", e.tag, e.cyc, Frame_Done, e.fd); end
      if (e.cyc == FL - 1) $display("[TB] tie_dwell: frame %0d checked", e.tag);
      tick();
    end
  endtask

  // Hand-over on release, then a fresh owner contended from mid first frame
  task automatic test_dwell_enforced();
    exp_t e;
    Req = 2'b10;
    push_frame(2'b01, 16'h1234, 1'b1, 6);
    push_frame(2'b10, 16'hABCD, 1'b1, 7);
    push_frame(2'b01, 16'h1234, 1'b1, 8);
    push_frame(2'b01, 16'h1234, 1'b1, 9);
    push_frame(2'b10, 16'hABCD, 1'b1, 10);
    for (int k = 0; k < 5 * FL; k++) begin
      e = sb.pop_front();
      if (k == FL)          Req = 2'b01;
      if (k == 2 * FL + 12) Req = 2'b11;
      n_tests += 4;
      if (Grant !== e.grant) begin n_fail++; $display("FAIL dwell grant f%0d c%0d: got %b want %b", e.tag, e.cyc, Grant, e.grant); end
      if (AN !== e.an) begin n_fail++; $display("FAIL dwell an f%0d c%0d: got %b want %b", e.tag, e.cyc, AN, e.an); end
      if (Code !== e.code) begin n_fail++; $display("FAIL dwell code f%0d c%0d: got %h want %h", e.tag, e.cyc, Code, e.code); end
      if (Frame_Done !== e.fd) begin n_fail++; $display("FAIL dwell frame_done f%0d c%0d: got %b want %b", e.tag, e.cyc, Frame_Done, e.fd); end
      if (e.cyc == FL - 1) $display("[TB] dwell_enforced: frame %0d checked", e.tag);
      tick();
    end
  endtask

  task automatic test_single();
    exp_t e;
    Req = 2'b01;
    push_frame(2'b10, 16'hABCD, 1'b1, 11);
    push_frame(2'b01, 16'h1234, 1'b1, 12);
    for (int k = 0; k < 2 * FL; k++) begin
      e = sb.pop_front();
      n_tests += 4;
      if (Grant !== e.grant) begin n_fail++; $display("FAIL single grant f%0d c%0d: got %b want %b", e.tag, e.cyc, Grant, e.grant); end
      if (AN !== e.an) begin n_fail++; $display("FAIL single an f%0d c%0d: got %b want %b", e.tag, e.cyc, AN, e.an); end
      if (Code !== e.code) begin n_fail++; $display("FAIL single code f%0d c%0d: got %h want %h", e.tag, e.cyc, Code, e.code); end
      if (Frame_Done !== e.fd) begin n_fail++; $display("FAIL single frame_done f%0d c%0d: got %b want %b", e.tag, e.cyc, Frame_Done, e.fd); end
      if (e.cyc == FL - 1) $display("[TB] single: frame %0d checked", e.tag);
      tick();
    end
  endtask

  task automatic test_snapshot();
    exp_t e;
    push_frame(2'b01, 16'h1234, 1'b1, 13);
    push_frame(2'b01, 16'h5678, 1'b1, 14);
    for (int k = 0; k < 2 * FL; k++) begin
      e = sb.pop_front();
      if (k == SD + 2) Data0 = 16'h5678;
      n_tests += 4;
      if (Grant !== e.grant) begin n_fail++; $display("FAIL snapshot grant f%0d c%0d: got %b want %b", e.tag, e.cyc, Grant, e.grant); end
      if (AN !== e.an) begin n_fail++; $display("FAIL snapshot an f%0d c%0d: got %b want %b", e.tag, e.cyc, AN, e.an); end
      if (Code !== e.code) begin n_fail++; $display("FAIL snapshot code f%0d c%0d: got %h want %h", e.tag, e.cyc, Code, e.code); end
      if (Frame_Done !== e.fd) begin n_fail++; $display("FAIL snapshot frame_done f%0d c%0d: got %b want %b", e.tag, e.cyc, Frame_Done, e.fd); end
      if (e.cyc == FL - 1) $display("[TB] snapshot: frame %0d checked", e.tag);
      tick();
    end
  endtask

  // Release to idle, re-grant, then reset in the middle of a granted frame
  task automatic test_release_reset();
    exp_t e;
    Req = 2'b00;
    push_frame(2'b01, 16'h5678, 1'b1, 15);
    push_frame(2'b00, 16'h0000, 1'b1, 16);
    push_frame(2'b00, 16'h0000, 1'b1, 17);
    push_frame(2'b01, 16'h5678, 1'b1, 18);
    for (int k = 0; k < 3 * FL + 14; k++) begin
      e = sb.pop_front();
      if (k == 2 * FL) Req = 2'b01;
      n_tests += 4;
      if (Grant !== e.grant) begin n_fail++; $display("FAIL release grant f%0d c%0d: got %b want %b", e.tag, e.cyc, Grant, e.grant); end
      if (AN !== e.an) begin n_fail++; $display("FAIL release an f%0d c%0d: got %b want %b", e.tag, e.cyc, AN, e.an); end
      if (Code !== e.code) begin n_fail++; $display("FAIL release code f%0d c%0d: got %h want %h", e.tag, e.cyc, Code, e.code); end
      if (Frame_Done !== e.fd) begin n_fail++; $display("FAIL release frame_done f%0d c%0d: got %b want %b", e.tag, e.cyc, Frame_Done, e.fd); end
      if (e.cyc == FL - 1) $display("[TB] release: frame %0d checked", e.tag);
      if (k == 3 * FL + 13) Reset = 1'b0;
      tick();
    end
    sb.delete();
    Reset = 1'b1;
    push_frame(2'b00, 16'h0000, 1'b0, 19);
    push_frame(2'b01, 16'h5678, 1'b1, 20);
    for (int k = 0; k < 2 * FL; k++) begin
      e = sb.pop_front();
      n_tests += 4;
      if (Grant !== e.grant) begin n_fail++; $display("FAIL midreset grant f%0d c%0d: got %b want %b", e.tag, e.cyc, Grant, e.grant); end
      if (AN !== e.an) begin n_fail++; $display("FAIL midreset an f%0d c%0d: got %b want %b", e.tag, e.cyc, AN, e.an); end
      if (Code !== e.code) begin n_fail++; $display("FAIL midreset code f%0d c%0d: got %h want %h", e.tag, e.cyc, Code, e.code); end
      if (Frame_Done !== e.fd) begin n_fail++; $display("FAIL midreset frame_done f%0d c%0d: got %b want %b", e.tag, e.cyc, Frame_Done, e.fd); end
      if (e.cyc == FL - 1) $display("[TB] midreset: frame %0d checked", e.tag);
      tick();
    end
  endtask

  initial begin
    Reset = 1'b0;
    Req   = 2'b00;
    Data0 = 16'h0000;
    Data1 = 16'h0000;
    test_reset();
    test_tie_dwell();
    test_dwell_enforced();
    test_single();
    test_snapshot();
    test_release_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/display_scan_arbiter.md
# display_scan_arbiter

Controller that time-shares the 4-digit seven-segment display between two 16-bit data sources and sequences the digit scan. It replaces free-running digit selection with a scan that includes a blanking interval per digit, which prevents ghosting. Each frame latches a coherent snapshot of the granted source. Ownership switches only at frame boundaries, with a minimum dwell time. It sits between the data producers (ALU result, counter) and the existing nibble-to-segment translator, which consumes `Code`.

## Interface
Parameters:
- `SCAN_DIV`, default 262144: cycles per digit slot. Must be ≥ 2.
- `BLANK_CYC`, default 1024: blanked cycles at the start of each slot. Must satisfy 1 ≤ BLANK_CYC < SCAN_DIV.
- `MIN_FRAMES`, default 8: minimum frames an owner keeps the display before a contending requester can take it. Must be ≥ 1.

Ports:
- `CLK`  in  1  system clock. One clock domain.
- `Reset`  in  1  **synchronous, active-low** reset.
- `Req`  in  2  request from source 0 and source 1. Level-sensitive.
- `Data0`  in  16  source 0 value. Nibble `[3:0]` is digit 0, `[15:12]` is digit 3.
- `Data1`  in  16  source 1 value, same layout as `Data0`.
- `Grant`  out  2  one-hot current owner. `00` means idle.
- `AN`  out  4  digit enables, active-low.
- `Code`  out  4  nibble for the translator.
- `Frame_Done`  out  1  one-cycle pulse after each frame boundary.

## Operation
- Scan timer:
  - `slot_cnt` counts 0..SCAN_DIV-1 and wraps.
  - `digit` (0..3) increments when `slot_cnt` wraps, and wraps 3→0.
  - Frame boundary (FB) is the cycle where `slot_cnt == SCAN_DIV-1` and `digit == 3`.
- Phases within a slot:
  - BLANK: `slot_cnt < BLANK_CYC`. `AN = 4'b1111`.
  - ON: all remaining cycles of the slot. `AN = ~(1 << digit)`, but only if `Grant != 00`; otherwise `AN = 4'b1111`.
- `Code` = `shadow[4*digit +: 4]`. It changes only at slot start, so it is stable for the whole BLANK phase before `AN` enables.
- Owner state machine with states IDLE, OWN0, OWN1. It is evaluated only on FB cycles. Let `other` be the non-owner source.
  - IDLE: if one `Req` is high, grant that source. If both are high, grant the source ≠ `last`. If neither is high, stay in IDLE.
  - OWNx, `Req[x]` low: release. Go to OWN`other` if `Req[other]` is high, else go to IDLE.
  - OWNx, `Req[x]` high, `Req[other]` high, `frames ≥ MIN_FRAMES`: go to OWN`other`.
  - Otherwise: hold the current state.
- `last` records the most recently granted source. It resets to 1, so source 0 wins the first tie.
- `frames` counts completed frames under the current owner.
  - It saturates at MIN_FRAMES.
  - It clears to 0 on any owner change, including into or out of IDLE.
- Snapshot: on FB, `shadow` is loaded from the data of the *next* owner. If the next state is IDLE, `shadow` is loaded with 0. A mid-frame data change never alters the displayed frame.
- `Req` changes between FBs are ignored. A request shorter than one frame that falls between FBs is never seen.

## Timing
- All outputs are registered.
- `Grant`, `shadow`, and `frames` update on the clock edge ending the FB cycle.
- The new frame starts on the next cycle with `digit = 0` and `slot_cnt = 0`, in the BLANK phase.
- `Frame_Done` is high for exactly the first cycle of each frame, i.e. the cycle after FB.
- Frame length is 4·SCAN_DIV cycles.
- Worst-case grant latency from `Req` assertion:
  - 4·SCAN_DIV cycles when the display is idle.
  - (MIN_FRAMES+1)·4·SCAN_DIV cycles when contended.
- Reset (`Reset == 0` at a clock edge) forces, on the next cycle:
  - `slot_cnt = 0`, `digit = 0`.
  - `Grant = 00`, `AN = 4'b1111`, `Code = 4'h0`, `Frame_Done = 0`.
  - `shadow = 0`, `frames = 0`, `last = 1`.
- Reset behaves the same mid-frame and mid-grant. No partial-frame output follows reset.
- After reset release, the first FB occurs 4·SCAN_DIV cycles later. `Frame_Done` does not pulse for the reset cycle.

## Structure
- Shared package holds:
  - `AN_OFF = 4'b1111`.
  - Owner state enum: `OWN_IDLE`, `OWN_0`, `OWN_1`.
  - `GRANT_NONE = 2'b00`.
- Sub-module `display_scan_timer`, parameterized by SCAN_DIV and BLANK_CYC.
  - Owns `slot_cnt` and `digit`.
  - Outputs `digit`, `blank`, `slot_start`, `fb`.
- The top level holds the arbiter FSM, `frames`, `last`, `shadow`, and the output registers.

## Test plan
All scenarios use SCAN_DIV=8, BLANK_CYC=2, MIN_FRAMES=2, so one frame is 32 cycles.
- **Reset.** Hold `Reset=0` for 3 cycles with `Req=11`, then release. Required: `Grant=00`, `AN=1111`, `Code=0` throughout. First `Frame_Done` arrives 32 cycles after release, and `Grant=01` on that same cycle.
- **Single requester.** `Req=01`, `Data0=16'h1234`. Required:
  - First granted frame, slot 0: cycles 0-1 show `AN=1111`, `Code=4`; cycles 2-7 show `AN=1110`.
  - Slot 3: `Code=1`, `AN=0111` in the ON phase.
- **Tie and dwell.** `Req=11`, `Data1=16'hABCD`. Required: `Grant=01` for exactly 2 frames, then `Grant=10`. Digit 0 then shows `Code=D`. Alternation continues every 2 frames.
- **Dwell enforced.** Source 0 is owner after 1 frame when `Req[1]` rises mid-frame. Required: no switch at the next FB; switch at the following FB.
- **Snapshot coherence.** Change `Data0` from `16'h1234` to `16'h5678` during slot 1. Required: the current frame keeps showing 3, 2, 1 for slots 1-3. The next frame shows 8, 7, 6, 5.
- **Release and mid-grant reset.** Drop `Req[0]` while owner with `Req[1]=0`. Required: `Grant=00` after the next FB, and `AN=1111` for all following cycles. Then assert `Reset=0` mid-frame while granted. Required: all reset values on the next cycle.
